// File: rtl/div_pkg.sv
// Shared width, counter sizing and FSM state encoding for the sequential divider.
// Consumed by seq_divider16 and div_sub_stage.
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring shift-subtract step: trial subtract as rem + ~divisor + 1.
// Combinational, zero latency; no handshake.
module div_sub_stage
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic             q_bit
);

  logic [WIDTH+1:0] sum_full;

  // The carry out of the WIDTH+1 bit add is the inverted borrow: set when rem_shifted >= divisor.
  assign sum_full = {1'b0, rem_shifted} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign q_bit    = sum_full[WIDTH+1];
  assign next_rem = q_bit ? sum_full[WIDTH:0] : rem_shifted;

endmodule

// File: rtl/seq_divider16.sv
// Restoring divider, one quotient bit per clock; DIV_SIGNED_EN selects two's complement operands.
// Latency: result valid WIDTH+1 cycles after accept (1 cycle for a zero divisor).
// Backpressure: result held while out_ready=0; in_ready low from accept until result is taken.
module seq_divider16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH:0]   rem_reg;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   rem_shifted;
  logic [WIDTH:0]   next_rem;
  logic             q_bit;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             accept;

  assign accept      = in_valid && in_ready;
  assign rem_shifted = (WIDTH+1)'({rem_reg, quo_reg[WIDTH-1]});
  assign quo_step    = {quo_reg[WIDTH-2:0], q_bit};

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .rem_shifted (rem_shifted),
    .divisor     (dvs_reg),
    .next_rem    (next_rem),
    .q_bit       (q_bit)
  );

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Magnitudes feed the unsigned core; 0x8000 maps to itself, which is the correct unsigned magnitude.
  assign dd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign dv_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_final = neg_q ? -quo_step : quo_step;
  assign r_final = neg_r ? -next_rem[WIDTH-1:0] : next_rem[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && accept) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign dd_mag  = dividend;
  assign dv_mag  = divisor;
  assign q_final = quo_step;
  assign r_final = next_rem[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              quo_reg <= dd_mag;
              dvs_reg <= dv_mag;
              rem_reg <= '0;
              count   <= CNT_W'(WIDTH - 1);
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_reg <= next_rem;
          quo_reg <= quo_step;
          if (count == '0) begin
            quotient    <= q_final;
            remainder   <= r_final;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        DONE: begin
          // New operands are only taken from IDLE, one cycle after the result is consumed.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
